// File: rtl/time_param_programmer_pkg.sv
// ----------------------------------------------------------------------------
// time_param_programmer_pkg
//   Shared definitions for the alarm time-parameter store and its write-side
//   programmer. It holds the slot indices, the default delays in seconds, and
//   the programmer state type.
// ----------------------------------------------------------------------------
package time_param_programmer_pkg;

   // Parameter slot indices, as seen on time_parameter_selector
   localparam int unsigned SEL_ARM       = 0;
   localparam int unsigned SEL_DRIVER    = 1;
   localparam int unsigned SEL_PASSENGER = 2;
   localparam int unsigned SEL_ALARM_ON  = 3;

   // Power-on default delays (seconds) held by the store
   localparam int unsigned DEF_ARM_DELAY       = 6;
   localparam int unsigned DEF_DRIVER_DELAY    = 8;
   localparam int unsigned DEF_PASSENGER_DELAY = 15;
   localparam int unsigned DEF_ALARM_ON_DELAY  = 10;

   typedef enum logic [1:0] {
      PROG_IDLE    = 2'd0,
      PROG_WRITE   = 2'd1,
      PROG_CONFIRM = 2'd2,
      PROG_ERROR   = 2'd3
   } prog_state_e;

endpackage

// File: rtl/time_param_programmer_rise_edge_detect.sv
// ----------------------------------------------------------------------------
// time_param_programmer_rise_edge_detect
//   Rising-edge detector for a level input. It produces a 1-cycle pulse.
//   RESET_VAL sets the remembered previous level after reset. With
//   RESET_VAL=1, an input that is already high when reset is released does
//   not count as an edge.
// Ports
//   clk      in  system clock
//   reset    in  asynchronous, active-high reset
//   level_in in  level to watch
//   rise_out out level_in & ~previous level (combinational)
// ----------------------------------------------------------------------------
module time_param_programmer_rise_edge_detect #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic level_in,
   output logic rise_out
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = level_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= RESET_VAL;
      else       prev_q <= prev_d;
   end

   assign rise_out = level_in & ~prev_q;

endmodule

// File: rtl/time_param_programmer.sv
// ----------------------------------------------------------------------------
// time_param_programmer
//   Write-side controller for the alarm time-parameter store. It turns one
//   reprogram press into one validated write over a req/ack handshake.
//   Values below MIN_VALUE are rejected. A store that never answers is timed
//   out. The status LED gives feedback: blinking after a commit, steady on
//   an error.
// Ports
//   clk, reset               clock, asynchronous active-high reset
//   reprogram                debounced button level
//   time_parameter_selector  slot to write
//   time_value               value to write (seconds)
//   one_hz_enable            1-cycle tick for feedback timing
//   wr_req/wr_sel/wr_data    write request and latched payload
//   wr_ack                   store accepted the write
//   commit                   1-cycle pulse on an accepted write
//   busy / error             not idle / in error feedback
//   status_led               feedback LED
//   last_sel / last_value    last committed write
// ----------------------------------------------------------------------------
module time_param_programmer
   import time_param_programmer_pkg::*;
#(
   parameter int unsigned SEL_W         = 2,
   parameter int unsigned VAL_W         = 4,
   parameter int unsigned MIN_VALUE     = 1,
   parameter int unsigned ACK_TIMEOUT   = 15,
   parameter int unsigned CONFIRM_TICKS = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             reprogram,
   input  logic [SEL_W-1:0] time_parameter_selector,
   input  logic [VAL_W-1:0] time_value,
   input  logic             one_hz_enable,
   output logic             wr_req,
   output logic [SEL_W-1:0] wr_sel,
   output logic [VAL_W-1:0] wr_data,
   input  logic             wr_ack,
   output logic             commit,
   output logic             busy,
   output logic             error,
   output logic             status_led,
   output logic [SEL_W-1:0] last_sel,
   output logic [VAL_W-1:0] last_value
);

   localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned TICK_W = $clog2(2 * CONFIRM_TICKS + 1);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(ACK_TIMEOUT);
   localparam logic [TICK_W-1:0] CONF_LAST = TICK_W'(2 * CONFIRM_TICKS - 1);
   localparam logic [TICK_W-1:0] ERR_LAST  = TICK_W'(CONFIRM_TICKS - 1);
   localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(2 * CONFIRM_TICKS);

   prog_state_e      state_q, state_d;
   logic             wr_req_q, wr_req_d;
   logic [SEL_W-1:0] wr_sel_q, wr_sel_d;
   logic [VAL_W-1:0] wr_data_q, wr_data_d;
   logic             commit_q, commit_d;
   logic             busy_q, busy_d;
   logic             error_q, error_d;
   logic             led_q, led_d;
   logic [SEL_W-1:0] last_sel_q, last_sel_d;
   logic [VAL_W-1:0] last_value_q, last_value_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             press;

   time_param_programmer_rise_edge_detect #(
      .RESET_VAL (1'b1)
   ) u_press_edge (
      .clk      (clk),
      .reset    (reset),
      .level_in (reprogram),
      .rise_out (press)
   );

   // Next state and registered outputs. Outputs are computed here from the
   // transition being taken, so each one changes on the same edge as state.
   always_comb begin
      state_d      = state_q;
      wr_req_d     = wr_req_q;
      wr_sel_d     = wr_sel_q;
      wr_data_d    = wr_data_q;
      commit_d     = 1'b0;
      led_d        = led_q;
      last_sel_d   = last_sel_q;
      last_value_d = last_value_q;

      unique case (state_q)
         PROG_IDLE: begin
            led_d = 1'b0;
            if (press) begin
               wr_sel_d  = time_parameter_selector;
               wr_data_d = time_value;
               if (time_value < VAL_W'(MIN_VALUE)) begin
                  state_d = PROG_ERROR;
                  led_d   = 1'b1;
               end else begin
                  state_d  = PROG_WRITE;
                  wr_req_d = 1'b1;
               end
            end
         end
         PROG_WRITE: begin
            // An ack that arrives in the final timeout cycle still wins
            if (wr_ack) begin
               state_d      = PROG_CONFIRM;
               wr_req_d     = 1'b0;
               commit_d     = 1'b1;
               led_d        = 1'b1;
               last_sel_d   = wr_sel_q;
               last_value_d = wr_data_q;
            end else if (wait_cnt_q == WAIT_LAST) begin
               state_d  = PROG_ERROR;
               wr_req_d = 1'b0;
               led_d    = 1'b1;
            end
         end
         PROG_CONFIRM: begin
            if (one_hz_enable) begin
               if (tick_cnt_q == CONF_LAST) begin
                  state_d = PROG_IDLE;
                  led_d   = 1'b0;
               end else begin
                  led_d = ~led_q;
               end
            end
         end
         PROG_ERROR: begin
            if (one_hz_enable && (tick_cnt_q == ERR_LAST)) begin
               state_d = PROG_IDLE;
               led_d   = 1'b0;
            end
         end
         default: state_d = PROG_IDLE;
      endcase

      busy_d  = (state_d != PROG_IDLE);
      error_d = (state_d == PROG_ERROR);
   end

   // Counters clear on any state change. Because of that, a tick in the
   // entry cycle (still the old state) is never counted.
   always_comb begin
      wait_cnt_d = '0;
      if ((state_q == PROG_WRITE) && (state_d == PROG_WRITE))
         wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);

      tick_cnt_d = tick_cnt_q;
      if (state_d != state_q)
         tick_cnt_d = '0;
      else if (((state_q == PROG_CONFIRM) || (state_q == PROG_ERROR)) &&
               one_hz_enable && (tick_cnt_q != TICK_MAX))
         tick_cnt_d = tick_cnt_q + TICK_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= PROG_IDLE;
         wr_req_q     <= 1'b0;
         wr_sel_q     <= '0;
         wr_data_q    <= '0;
         commit_q     <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
         led_q        <= 1'b0;
         last_sel_q   <= '0;
         last_value_q <= '0;
         wait_cnt_q   <= '0;
         tick_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         wr_req_q     <= wr_req_d;
         wr_sel_q     <= wr_sel_d;
         wr_data_q    <= wr_data_d;
         commit_q     <= commit_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
         led_q        <= led_d;
         last_sel_q   <= last_sel_d;
         last_value_q <= last_value_d;
         wait_cnt_q   <= wait_cnt_d;
         tick_cnt_q   <= tick_cnt_d;
      end
   end

   assign wr_req     = wr_req_q;
   assign wr_sel     = wr_sel_q;
   assign wr_data    = wr_data_q;
   assign commit     = commit_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign status_led = led_q;
   assign last_sel   = last_sel_q;
   assign last_value = last_value_q;

endmodule

// File: tb/tb_time_param_programmer.sv
module tb_time_param_programmer;

   localparam int MIN_V   = 1;
   localparam int TIMEOUT = 15;
   localparam int CT      = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       reprogram = 1'b0;
   logic [1:0] sel_in = '0;
   logic [3:0] val_in = '0;
   logic       one_hz = 1'b0;
   logic       wr_ack = 1'b0;
   logic       wr_req, commit, busy, error, status_led;
   logic [1:0] wr_sel, last_sel;
   logic [3:0] wr_data, last_value;

   int errors = 0;
   int checks = 0;

   // reference model state: last committed write
   logic [1:0] m_last_sel = '0;
   logic [3:0] m_last_val = '0;

   time_param_programmer #(
      .SEL_W(2), .VAL_W(4), .MIN_VALUE(MIN_V), .ACK_TIMEOUT(TIMEOUT), .CONFIRM_TICKS(CT)
   ) dut (
      .clk(clk), .reset(reset), .reprogram(reprogram),
      .time_parameter_selector(sel_in), .time_value(val_in),
      .one_hz_enable(one_hz), .wr_req(wr_req), .wr_sel(wr_sel), .wr_data(wr_data),
      .wr_ack(wr_ack), .commit(commit), .busy(busy), .error(error),
      .status_led(status_led), .last_sel(last_sel), .last_value(last_value)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      reprogram = 1'b1;            // held through reset release
      #12;
      checks++;
      if ({wr_req, commit, busy, error, status_led, wr_sel, wr_data, last_sel, last_value} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got req=%0b commit=%0b busy=%0b err=%0b led=%0b last=%0d/%0d, expected all 0",
                  wr_req, commit, busy, error, status_led, last_sel, last_value);
      end
      @(negedge clk); reset = 1'b0;
      begin
         bit seen = 0;
         repeat (5) begin
            @(negedge clk);
            if (wr_req || busy) seen = 1;
         end
         checks++;
         if (seen) begin
            errors++;
            $display("FAIL reset_held_button: got write activity, expected none");
         end
      end
      reprogram = 1'b0;
      @(negedge clk);
   endtask

   // One press and its whole outcome. d = wait cycle index in which ack is
   // raised (>= TIMEOUT means the store never answers).
   task automatic run_write(input logic [1:0] s, input logic [3:0] v, input int d,
                            input bit tick_on_entry, input bit hold_btn, input bit extra);
      int  highs = 0;
      int  ticks = 0;
      int  changes = 0;
      int  exp_ticks;
      int  exp_highs;
      bit  unstable = 0;
      bit  bad_commit = 0;
      bit  success;
      logic prev_led;

      success = (v >= MIN_V) && (d < TIMEOUT);
      exp_highs = (v < MIN_V) ? 0 : ((d < TIMEOUT) ? d + 1 : TIMEOUT);
      @(negedge clk);
      prev_led = status_led;
      sel_in = s; val_in = v; reprogram = 1'b1;
      if (tick_on_entry) one_hz = 1'b1;
      @(negedge clk);
      one_hz = 1'b0;
      if (!hold_btn) reprogram = 1'b0;
      sel_in = ~s; val_in = ~v;    // latched copy must not follow inputs

      if (v < MIN_V) begin
         checks++;
         if (wr_req !== 1'b0 || error !== 1'b1 || busy !== 1'b1 || status_led !== 1'b1) begin
            errors++;
            $display("FAIL reject_entry: got req=%0b err=%0b busy=%0b led=%0b, expected 0 1 1 1",
                     wr_req, error, busy, status_led);
         end
      end else begin
         checks++;
         if (wr_req !== 1'b1 || wr_sel !== s || wr_data !== v || busy !== 1'b1) begin
            errors++;
            $display("FAIL write_latch: got req=%0b sel=%0d data=%0d busy=%0b, expected 1 %0d %0d 1",
                     wr_req, wr_sel, wr_data, busy, s, v);
         end
         for (int k = 0; k < TIMEOUT + 5; k++) begin
            if (wr_req === 1'b1) highs++;
            if (wr_sel !== s || wr_data !== v) unstable = 1;
            if (extra) reprogram = k[0];
            if (k == d) begin
               wr_ack = 1'b1;
               if (tick_on_entry) one_hz = 1'b1;
            end
            @(negedge clk);
            wr_ack = 1'b0; one_hz = 1'b0;
            if (wr_req !== 1'b1) break;
         end
         if (extra) reprogram = hold_btn;
         checks++;
         if (highs != exp_highs || unstable) begin
            errors++;
            $display("FAIL req_duration: got %0d cycles (unstable=%0b), expected %0d", highs, unstable, exp_highs);
         end
         checks++;
         if (success) begin
            m_last_sel = s; m_last_val = v;
            if (commit !== 1'b1 || status_led !== 1'b1 || last_sel !== s || last_value !== v) begin
               errors++;
               $display("FAIL commit_entry: got commit=%0b led=%0b last=%0d/%0d, expected 1 1 %0d/%0d",
                        commit, status_led, last_sel, last_value, s, v);
            end
         end else if (commit !== 1'b0 || error !== 1'b1 || status_led !== 1'b1) begin
            errors++;
            $display("FAIL timeout_entry: got commit=%0b err=%0b led=%0b, expected 0 1 1",
                     commit, error, status_led);
         end
      end

      if (status_led !== prev_led) changes++;
      prev_led = status_led;
      exp_ticks = success ? 2 * CT : CT;
      while (busy === 1'b1 && ticks < 4 * CT) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            if (commit !== 1'b0) bad_commit = 1;
         end
         one_hz = 1'b1;
         @(negedge clk);
         one_hz = 1'b0;
         ticks++;
         if (commit !== 1'b0) bad_commit = 1;
         if (status_led !== prev_led) changes++;
         prev_led = status_led;
      end
      checks++;
      if (ticks != exp_ticks || bad_commit) begin
         errors++;
         $display("FAIL feedback_ticks: got %0d ticks (extra commit=%0b), expected %0d", ticks, bad_commit, exp_ticks);
      end
      checks++;
      if (changes != (success ? 2 * CT : 2) || status_led !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL feedback_led: got %0d led changes led=%0b err=%0b busy=%0b, expected %0d 0 0 0",
                  changes, status_led, error, busy, success ? 2 * CT : 2);
      end
      checks++;
      if (last_sel !== m_last_sel || last_value !== m_last_val) begin
         errors++;
         $display("FAIL last_regs: got %0d/%0d, expected %0d/%0d", last_sel, last_value, m_last_sel, m_last_val);
      end
      begin
         bit again = 0;
         repeat (4) begin
            @(negedge clk);
            if (wr_req || busy) again = 1;
         end
         checks++;
         if (again) begin
            errors++;
            $display("FAIL no_second_write: got activity after idle, expected none");
         end
      end
      reprogram = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic_write();
      run_write(2'd2, 4'd9, 3, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reject();
      run_write(2'd1, 4'd0, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      run_write(2'd3, 4'd5, 100, 1'b0, 1'b0, 1'b0);
      run_write(2'd0, 4'd7, TIMEOUT - 1, 1'b1, 1'b0, 1'b0);   // ack in final cycle
      run_write(2'd1, 4'd6, TIMEOUT, 1'b0, 1'b0, 1'b0);       // one cycle too late
   endtask

   task automatic test_dropped_presses();
      run_write(2'd1, 4'd12, 6, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++)
         run_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 17)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      sel_in = 2'd2; val_in = 4'd4; reprogram = 1'b1;
      repeat (3) @(negedge clk);
      wr_ack = 1'b0;
      #2 reset = 1'b1;
      #1;
      m_last_sel = '0; m_last_val = '0;
      checks++;
      if ({wr_req, commit, busy, status_led, error, last_sel, last_value} !== '0) begin
         errors++;
         $display("FAIL reset_mid_write: got req=%0b commit=%0b busy=%0b led=%0b last=%0d/%0d, expected all 0",
                  wr_req, commit, busy, status_led, last_sel, last_value);
      end
      @(negedge clk); reset = 1'b0;
      begin
         bit seen = 0;
         repeat (5) begin
            @(negedge clk);
            if (wr_req || busy || commit) seen = 1;
         end
         checks++;
         if (seen) begin
            errors++;
            $display("FAIL reset_release_held: got write activity, expected none");
         end
      end
      reprogram = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stray_ack();
      bit bad = 0;
      @(negedge clk);
      wr_ack = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (commit || busy || wr_req) bad = 1;
      end
      wr_ack = 1'b0;
      @(negedge clk);
      checks++;
      if (bad || last_sel !== m_last_sel || last_value !== m_last_val) begin
         errors++;
         $display("FAIL stray_ack: got activity=%0b last=%0d/%0d, expected none %0d/%0d",
                  bad, last_sel, last_value, m_last_sel, m_last_val);
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_reject();
      test_timeout();
      test_dropped_presses();
      test_stray_ack();
      test_random();
      test_reset_mid_write();
      test_basic_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
